apb_cmd_master: RTL
===================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width; STRB_W = DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, maximum number of ACCESS cycles with PREADY low; 0 disables the timeout.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, named PCLK and PRESETn.
REQ-005 PCLK  input  1  clock; all state changes on the rising edge.
REQ-006 PRESETn  input  1  asynchronous active-low reset.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-009 cmd_write  input  1  1 = write, 0 = read.
REQ-010 cmd_addr  input  ADDR_W  target address.
REQ-011 cmd_wdata  input  DATA_W  write data.
REQ-012 cmd_strb  input  STRB_W  write byte strobes.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-015 rsp_rdata  output  DATA_W  read data; 0 for writes.
REQ-016 rsp_err  output  1  PSLVERR seen, or timeout.
REQ-017 rsp_timeout  output  1  transfer aborted by timeout.
REQ-018 PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE  output  APB4 requester signals, all registered.
REQ-019 PRDATA (DATA_W), PREADY (1), PSLVERR (1)  input  APB4 completer signals.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP.
REQ-022 cmd_ready SHALL be 1 only in IDLE; the handshake moves IDLE->SETUP and latches addr, wdata, strb and write.
REQ-023 In SETUP: PSEL=1, PENABLE=0, for exactly one cycle, then ACCESS.
REQ-024 In ACCESS: PSEL=1, PENABLE=1, held until PREADY=1 or timeout.
REQ-025 PADDR, PWRITE, PWDATA and PSTRB SHALL be stable from SETUP through the end of ACCESS.
REQ-026 PSTRB SHALL be 0 on reads.
REQ-027 On ACCESS with PREADY=1: capture PRDATA (reads only) and PSLVERR; next cycle PSEL=0, PENABLE=0, state RESP.
REQ-028 Latency: command accepted at cycle N -> PSEL at N+1 -> PENABLE at N+2; with zero wait states, rsp_valid at N+3.
REQ-029 Wait counter: cleared on entering ACCESS; increments each ACCESS cycle with PREADY=0; saturating, width clog2(TIMEOUT_CYC+1).
REQ-030 When the counter reaches TIMEOUT_CYC (TIMEOUT_CYC≠0) while PREADY=0: abort with PSEL=0, PENABLE=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, state RESP.
REQ-031 If PREADY=1 in the same cycle the counter reaches TIMEOUT_CYC, completion SHALL win: no timeout.
REQ-032 In RESP: rsp_valid=1 with rsp_rdata, rsp_err and rsp_timeout held stable until rsp_ready=1, then IDLE.
REQ-033 No new command is accepted in the RESP-handshake cycle; cmd_ready rises the following cycle.
REQ-034 PSEL SHALL never be high in IDLE or RESP; PENABLE=1 implies PSEL=1.
REQ-035 Inputs cmd_* SHALL be ignored outside the IDLE handshake.

Reset
REQ-036 On PRESETn=0, immediately: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, busy=0, wait counter 0.
REQ-037 cmd_ready SHALL be 0 while PRESETn=0 and 1 in the first cycle after release.
REQ-038 Reset mid-transfer SHALL abort it and drop any in-flight response.

Verification
REQ-039 Write addr 0x0C, data 0x14, strb 0xF, PREADY=1 -> PSEL at N+1, PENABLE at N+2, PWDATA=0x14 stable, rsp_valid at N+3, rsp_err=0.
REQ-040 Read addr 0x04 with 2 wait states, PRDATA=0xA5A5_0001 -> PENABLE high for 3 cycles, PSTRB=0, rsp_rdata=0xA5A5_0001.
REQ-041 Write with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0.
REQ-042 TIMEOUT_CYC=8, PREADY held 0 -> abort after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1, PSEL=0 the next cycle.
REQ-043 rsp_ready held 0 for 5 cycles -> rsp_valid and response fields stable, cmd_ready=0 throughout, cmd_ready=1 the cycle after the handshake.
REQ-044 PRESETn pulsed low mid-ACCESS -> PSEL and PENABLE drop asynchronously, rsp_valid never asserted, the next command runs normally.

Source files
------------

// File: rtl/apb_cmd_master.sv
// Command-to-APB4 requester: turns one valid/ready command into a single APB
// transfer and returns the result through a valid/ready response channel.
module apb_cmd_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    localparam int STRB_W     = DATA_W / 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic [STRB_W-1:0] PSTRB,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              busy
);

    localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] wcnt;

    assign busy = (state != IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            PWRITE      <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wcnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                        PWRITE    <= cmd_write;
                        PSTRB     <= cmd_write ? cmd_strb : '0;
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    wcnt    <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else begin
                        if (wcnt != CNT_MAX) wcnt <= wcnt + 1'b1;
                        // this cycle's increment would reach TIMEOUT_CYC
                        if (TIMEOUT_CYC != 0 && wcnt == TO_LAST) begin
                            PSEL        <= 1'b0;
                            PENABLE     <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
